// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared opcodes, FSM states and instruction field positions for
//           the multicycle CPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int INSTR_W = 24;
    localparam int OP_HI   = 23;
    localparam int OP_LO   = 20;
    localparam int WA_HI   = 19;
    localparam int WA_LO   = 16;
    localparam int RA1_HI  = 15;
    localparam int RA1_LO  = 12;
    localparam int RA2_HI  = 11;
    localparam int RA2_LO  = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_ADDI = 4'h4,
        OP_SUBI = 4'h5,
        OP_ANDI = 4'h6,
        OP_ORI  = 4'h7,
        OP_BEQ  = 4'h8,
        OP_BNE  = 4'h9,
        OP_MUL  = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MUL2      = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    function automatic logic is_imm_op(input opcode_e op);
        return op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_multicycle_if.sv
// ============================================================================
// Module  : cpu_multicycle_if
// Brief   : Program-load, run-control and result bus of the multicycle CPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_multicycle_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 6
);
    logic               imem_we;
    logic [PC_W-1:0]    imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               start;
    logic               busy;
    logic               halted;
    logic [DATA_W-1:0]  ALUResult;
    logic               Zero;
    logic [DATA_W-1:0]  cpu_out;

    modport master (
        output imem_we, imem_waddr, imem_wdata, start,
        input  busy, halted, ALUResult, Zero, cpu_out
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata, start,
        output busy, halted, ALUResult, Zero, cpu_out
    );
endinterface

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
// Module  : cpu_regfile
// Brief   : NUM_REGS x DATA_W register file, two async reads, one sync write,
//           R0 hard-wired to zero, out-of-range indices read 0 / drop writes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regfile #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               i_we,
    input  wire  [3:0]        i_waddr,
    input  wire  [DATA_W-1:0] i_wdata,
    input  wire  [3:0]        i_raddr1,
    input  wire  [3:0]        i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);
    localparam int         AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [4:0] c_NREGS = 5'(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wok;
    logic              w_rok1;
    logic              w_rok2;

    assign w_wok  = (i_waddr  != 4'd0) && ({1'b0, i_waddr}  < c_NREGS);
    assign w_rok1 = (i_raddr1 != 4'd0) && ({1'b0, i_raddr1} < c_NREGS);
    assign w_rok2 = (i_raddr2 != 4'd0) && ({1'b0, i_raddr2} < c_NREGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && w_wok) begin
            r_regs[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        if (w_rok1) o_rdata1 = r_regs[i_raddr1[AW-1:0]];
        if (w_rok2) o_rdata2 = r_regs[i_raddr2[AW-1:0]];
    end
endmodule

`default_nettype wire

// File: rtl/cpu_multicycle.sv
// ============================================================================
// Module  : cpu_multicycle
// Brief   : Parametrised FETCH/DECODE/EXECUTE/WRITEBACK CPU with program-load
//           port and start/halt handshake. Optional MUL opcode: CPU_MULT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 16,
    parameter int IMEM_DEPTH = 64,
    parameter int OUT_REG    = 15
) (
    input  wire             CLK,
    input  wire             reset,
    cpu_multicycle_if.slave io_bus
);
    localparam int PC_W = $clog2(IMEM_DEPTH);

    state_e             r_state;
    state_e             w_next;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  r_alu;
    logic               r_zero;
    logic               r_taken;
    logic [DATA_W-1:0]  r_cpu_out;

    opcode_e            w_op;
    logic [3:0]         w_wa;
    logic [7:0]         w_imm;
    logic [DATA_W-1:0]  w_imm_ext;
    logic [DATA_W-1:0]  w_rd1;
    logic [DATA_W-1:0]  w_rd2;
    logic [DATA_W-1:0]  w_alu;
    logic               w_is_alu;
    logic               w_rf_we;
    logic               w_out_we;
    logic               w_load_ok;

    assign w_op      = opcode_e'(r_ir[OP_HI:OP_LO]);
    assign w_wa      = r_ir[WA_HI:WA_LO];
    assign w_imm     = r_ir[IMM_HI:IMM_LO];
    assign w_imm_ext = DATA_W'(w_imm);
    assign w_load_ok = (r_state == S_IDLE) || (r_state == S_HALT);

`ifdef CPU_MULT_EN
    logic [DATA_W-1:0] r_prod;
    logic [DATA_W-1:0] w_prod;
    assign w_prod   = r_a * r_b;
    assign w_is_alu = (w_op inside {[OP_ADD:OP_ORI]}) || (w_op == OP_MUL);
`else
    assign w_is_alu = w_op inside {[OP_ADD:OP_ORI]};
`endif

    assign w_rf_we  = (r_state == S_WRITEBACK) && w_is_alu;
    assign w_out_we = w_rf_we && (w_wa == 4'(OUT_REG)) && (OUT_REG != 0) && (OUT_REG < NUM_REGS);

    cpu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (CLK),
        .rst      (reset),
        .i_we     (w_rf_we),
        .i_waddr  (w_wa),
        .i_wdata  (r_alu),
        .i_raddr1 (r_ir[RA1_HI:RA1_LO]),
        .i_raddr2 (r_ir[RA2_HI:RA2_LO]),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    // Program memory is deliberately left out of reset so a loaded program survives it
    always_ff @(posedge CLK) begin
        if (io_bus.imem_we && w_load_ok) begin
            r_imem[io_bus.imem_waddr] <= io_bus.imem_wdata;
        end
    end

    always_comb begin
        w_alu = r_a + r_b;
        case (w_op)
            OP_SUB, OP_SUBI: w_alu = r_a - r_b;
            OP_AND, OP_ANDI: w_alu = r_a & r_b;
            OP_OR,  OP_ORI:  w_alu = r_a | r_b;
            default:         w_alu = r_a + r_b;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (io_bus.start) w_next = S_FETCH;
            S_FETCH:        w_next = S_DECODE;
            S_DECODE:       w_next = (w_op == OP_HALT) ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                w_next = S_WRITEBACK;
`ifdef CPU_MULT_EN
                if (w_op == OP_MUL) w_next = S_MUL2;
`endif
            end
            S_MUL2:         w_next = S_WRITEBACK;
            S_WRITEBACK:    w_next = S_FETCH;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_zero    <= 1'b1;
            r_taken   <= 1'b0;
            r_cpu_out <= '0;
`ifdef CPU_MULT_EN
            r_prod    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_HALT: if (io_bus.start) r_pc <= '0;
                S_FETCH:        r_ir <= r_imem[r_pc];
                S_DECODE: begin
                    r_a <= w_rd1;
                    r_b <= is_imm_op(w_op) ? w_imm_ext : w_rd2;
                end
                S_EXECUTE: begin
                    // Branches only compare; ALUResult/Zero keep the last ALU value
                    r_taken <= ((w_op == OP_BEQ) && (r_a == r_b)) ||
                               ((w_op == OP_BNE) && (r_a != r_b));
                    if (w_is_alu && (w_op != OP_MUL)) begin
                        r_alu  <= w_alu;
                        r_zero <= (w_alu == '0);
                    end
`ifdef CPU_MULT_EN
                    if (w_op == OP_MUL) r_prod <= w_prod;
`endif
                end
                S_MUL2: begin
`ifdef CPU_MULT_EN
                    r_alu  <= r_prod;
                    r_zero <= (r_prod == '0);
`endif
                end
                S_WRITEBACK: begin
                    r_pc <= r_taken ? PC_W'(w_imm) : r_pc + 1'b1;
                    if (w_out_we) r_cpu_out <= r_alu;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.busy      = r_state inside {S_FETCH, S_DECODE, S_EXECUTE, S_MUL2, S_WRITEBACK};
    assign io_bus.halted    = (r_state == S_HALT);
    assign io_bus.ALUResult = r_alu;
    assign io_bus.Zero      = r_zero;
    assign io_bus.cpu_out   = r_cpu_out;
endmodule

`default_nettype wire

// File: tb/tb_cpu_multicycle.sv
// ============================================================================
// Module  : tb_cpu_multicycle
// Brief   : Directed self-checking bench for cpu_multicycle (8-bit, 16 regs, 64 words).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_multicycle;
    import cpu_pkg::*;

    localparam int DW  = 8;
    localparam int PCW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc;

    always #5 clk = ~clk;

    cpu_multicycle_if #(.DATA_W(DW), .PC_W(PCW)) bus ();

    cpu_multicycle #(
        .DATA_W     (DW),
        .NUM_REGS   (16),
        .IMEM_DEPTH (64),
        .OUT_REG    (15)
    ) dut (
        .CLK    (clk),
        .reset  (rst),
        .io_bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] wa,
                                        input logic [3:0] ra1, input logic [3:0] ra2,
                                        input logic [7:0] imm);
        return {op, wa, ra1, ra2, imm};
    endfunction

    task automatic load(input int a, input logic [23:0] w);
        @(negedge clk);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = PCW'(a);
        bus.imem_wdata = w;
        @(negedge clk);
        bus.imem_we    = 1'b0;
    endtask

    // cyc counts rising edges from the start-sampling edge until halted is seen
    task automatic run(input bit ld0, input logic [23:0] w0, output int n);
        @(negedge clk);
        bus.start = 1'b1;
        if (ld0) begin
            bus.imem_we    = 1'b1;
            bus.imem_waddr = '0;
            bus.imem_wdata = w0;
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.imem_we = 1'b0;
        n = 1;
        while (!bus.halted && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        bus.imem_we    = 1'b0;
        bus.imem_waddr = '0;
        bus.imem_wdata = '0;
        bus.start      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(bus.busy),      0);
        chk("rst_halted", 32'(bus.halted),    0);
        chk("rst_alu",    32'(bus.ALUResult), 0);
        chk("rst_zero",   32'(bus.Zero),      1);
        chk("rst_out",    32'(bus.cpu_out),   0);
        rst = 1'b0;

        // Test 1: reset asserted during EXECUTE of an ADD
        load(0, enc(OP_ADDI, 15, 0, 0, 9));
        load(1, enc(OP_ADD, 15, 15, 15, 0));
        load(2, enc(OP_HALT, 0, 0, 0, 0));
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("t1_pre_out",  32'(bus.cpu_out),   9);
        chk("t1_pre_alu",  32'(bus.ALUResult), 9);
        chk("t1_pre_busy", 32'(bus.busy),      1);
        rst = 1'b1;
        #1;
        chk("t1_busy", 32'(bus.busy),      0);
        chk("t1_alu",  32'(bus.ALUResult), 0);
        chk("t1_zero", 32'(bus.Zero),      1);
        chk("t1_out",  32'(bus.cpu_out),   0);
        @(negedge clk);
        chk("t1_idle_busy",   32'(bus.busy),   0);
        chk("t1_idle_halted", 32'(bus.halted), 0);
        rst = 1'b0;

        // Test 2: 5-3 into R15; start and imem_we while busy must be ignored
        load(0, enc(OP_ADDI, 1, 0, 0, 5));
        load(1, enc(OP_ADDI, 2, 0, 0, 3));
        load(2, enc(OP_SUB, 15, 1, 2, 0));
        load(3, enc(OP_HALT, 0, 0, 0, 0));
        fork
            run(1'b0, 24'h0, cyc);
            begin
                repeat (4) @(negedge clk);
                bus.imem_we    = 1'b1;
                bus.imem_waddr = 6'd3;
                bus.imem_wdata = enc(OP_ADDI, 15, 0, 0, 99);
                bus.start      = 1'b1;
                @(negedge clk);
                bus.imem_we    = 1'b0;
                bus.start      = 1'b0;
            end
        join
        chk("t2_halted", 32'(bus.halted),    1);
        chk("t2_cycles", 32'(cyc),           1 + 3*4 + 2);
        chk("t2_out",    32'(bus.cpu_out),   2);
        chk("t2_alu",    32'(bus.ALUResult), 2);
        chk("t2_zero",   32'(bus.Zero),      0);
        chk("t2_busy",   32'(bus.busy),      0);

        // Test 3: countdown loop from 3 with BNE, restarted from HALT
        load(0, enc(OP_ADDI, 1, 0, 0, 3));
        load(1, enc(OP_SUBI, 1, 1, 0, 1));
        load(2, enc(OP_BNE, 0, 1, 0, 1));
        load(3, enc(OP_ADD, 15, 1, 0, 0));
        load(4, enc(OP_HALT, 0, 0, 0, 0));
        run(1'b0, 24'h0, cyc);
        chk("t3_cycles", 32'(cyc),           1 + 4 + 3*8 + 4 + 2);
        chk("t3_out",    32'(bus.cpu_out),   0);
        chk("t3_alu",    32'(bus.ALUResult), 0);
        chk("t3_zero",   32'(bus.Zero),      1);

        // Test 4: writes to R0 are dropped
        load(0, enc(OP_ADDI, 15, 0, 0, 9));
        load(1, enc(OP_ADDI, 0, 0, 0, 7));
        load(2, enc(OP_ADD, 15, 0, 0, 0));
        load(3, enc(OP_HALT, 0, 0, 0, 0));
        run(1'b0, 24'h0, cyc);
        chk("t4_cycles", 32'(cyc),         1 + 3*4 + 2);
        chk("t4_out",    32'(bus.cpu_out), 0);
        chk("t4_zero",   32'(bus.Zero),    1);

        // Test 5a: 255 + 1 wraps to 0 at DATA_W=8
        load(0, enc(OP_ADDI, 15, 0, 0, 77));
        load(1, enc(OP_ADDI, 1, 0, 0, 255));
        load(2, enc(OP_ADDI, 15, 1, 0, 1));
        load(3, enc(OP_HALT, 0, 0, 0, 0));
        run(1'b0, 24'h0, cyc);
        chk("t5a_out",  32'(bus.cpu_out),   0);
        chk("t5a_alu",  32'(bus.ALUResult), 0);
        chk("t5a_zero", 32'(bus.Zero),      1);

        // Test 5b: PC 63 -> 0 wrap; word 0 written in the same cycle as start
        load(1, enc(OP_BEQ, 0, 0, 0, 63));
        load(2, enc(OP_ADDI, 15, 3, 0, 60));
        load(3, enc(OP_HALT, 0, 0, 0, 0));
        load(63, enc(OP_ADDI, 3, 0, 0, 1));
        run(1'b1, enc(OP_BNE, 0, 3, 0, 2), cyc);
        chk("t5b_cycles", 32'(cyc),         1 + 5*4 + 2);
        chk("t5b_out",    32'(bus.cpu_out), 61);

        // Test 6: MUL 12*11 (opcode A)
        load(0, enc(OP_ADDI, 15, 0, 0, 5));
        load(1, enc(OP_ADDI, 1, 0, 0, 12));
        load(2, enc(OP_ADDI, 2, 0, 0, 11));
        load(3, enc(OP_MUL, 15, 1, 2, 0));
        load(4, enc(OP_HALT, 0, 0, 0, 0));
        run(1'b0, 24'h0, cyc);
`ifdef CPU_MULT_EN
        chk("t6_cycles", 32'(cyc),           1 + 3*4 + 5 + 2);
        chk("t6_out",    32'(bus.cpu_out),   132);
        chk("t6_alu",    32'(bus.ALUResult), 132);
`else
        chk("t6_cycles", 32'(cyc),           1 + 4*4 + 2);
        chk("t6_out",    32'(bus.cpu_out),   5);
        chk("t6_alu",    32'(bus.ALUResult), 11);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
